if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the main control decoder.
- Holds the PC and issues one-at-a-time requests to instruction memory with a req/valid handshake.
- Registers each returned word into the IF/ID register; the decoder consumes `opCode` from that register.
- Supports a load-use stall, with a one-entry skid buffer, and branch redirect with flush.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ADDR_W, 32: PC and address width.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- imemReq, output, 1: one-cycle request pulse to instruction memory.
- imemAddr, output, ADDR_W: request address; equals pc whenever imemReq=1.
- imemRdata, input, 32: returned instruction word.
- imemValid, input, 1: imemRdata valid this cycle; ignored outside WAIT.
- stall, input, 1: hazard unit holds the IF/ID register.
- branchTaken, input, 1: redirect pulse from the branch logic.
- branchTarget, input, ADDR_W: redirect address; bits [1:0] are forced to 0.
- instrOut, output, 32: IF/ID instruction.
- opCode, output, 6: equals instrOut[31:26]; goes to the control decoder.
- pcPlus4Out, output, ADDR_W: IF/ID copy of fetch pc+4.
- ifidValid, output, 1: IF/ID holds a real instruction.

Behaviour:
- Reset (async assert on rst_n=0, sync release):
  - pc=RESET_PC, state=FETCH, skid empty, discard=0.
  - instrOut=0, opCode=0, pcPlus4Out=0, ifidValid=0.
  - A zero instruction is a NOP: all-zero opcode with a $0 destination.
- FSM states:
  - FETCH: imemReq = !branchTaken (combinational); imemAddr=pc. Next state is WAIT if a request was issued, otherwise stay in FETCH.
  - WAIT: imemReq=0; waits any number of cycles for imemValid.
    - On imemValid with discard=1: drop the word, clear discard, go to FETCH.
    - On imemValid with stall=0: load IF/ID (instrOut=imemRdata, pcPlus4Out=pc+4, ifidValid=1), set pc=pc+4, go to FETCH.
    - On imemValid with stall=1: write imemRdata into the skid buffer, go to HOLD. pc is unchanged.
  - HOLD: imemReq=0. When stall=0, load IF/ID from the skid buffer, set pc=pc+4, empty the skid, go to FETCH.
- Stall:
  - While stall=1, all IF/ID outputs hold their values, including ifidValid.
  - A request already issued completes into the skid buffer.
  - FETCH still issues its request while stalled.
- Branch redirect (branchTaken=1, any state, highest priority):
  - pc = {branchTarget[ADDR_W-1:2], 2'b00}.
  - IF/ID is flushed next edge: instrOut=0, ifidValid=0, pcPlus4Out=0. The flush overrides stall.
  - In FETCH: no request this cycle; stay in FETCH.
  - In WAIT with imemValid low that cycle: set discard=1 and stay in WAIT.
  - In WAIT with imemValid high the same cycle: drop the word and go to FETCH.
  - In HOLD: empty the skid buffer and go to FETCH.
- Throughput and latency:
  - With memory answering the cycle after the request, the stage delivers one instruction every 2 cycles.
  - IF/ID updates on the edge that samples imemValid.
- Arithmetic: pc+4 wraps modulo 2^ADDR_W; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Reset mid-transaction: everything returns to reset values immediately. A late imemValid after release arrives while in FETCH and is ignored.
- At most one request is outstanding at any time.

Test Plan:
- Reset release, RESET_PC=0, memory returns 32'h8C01_0004 one cycle after each request. Required response:
  - imemReq pulses at addr 0, then at addr 4.
  - instrOut=32'h8C01_0004, opCode=6'b100011, pcPlus4Out=4, ifidValid=1.
- Stall held 3 cycles while the word for addr 4 returns. Required response:
  - IF/ID keeps its prior values.
  - After stall drops, IF/ID loads the addr-4 word with pcPlus4Out=8, and the next request goes to addr 8.
- branchTaken with branchTarget=32'h0000_0043 during WAIT, memory replying 2 cycles later. Required response:
  - Reply is discarded and ifidValid=0.
  - Next request is at 32'h0000_0040.
- branchTaken during HOLD while stall=1. Required response:
  - Skid buffer dropped; IF/ID flushed to 0 despite the stall.
  - Next request at the target address.
- pc=32'hFFFF_FFFC fetch. Required response: pcPlus4Out=0 and the next request is at addr 0.
- rst_n asserted during WAIT. Required response:
  - All outputs reset immediately.
  - After release, an imemValid in the first cycle is ignored and the first request is at RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, issues single outstanding imem requests,
// and fills the IF/ID register (with a one-word skid for load-use stalls).
module if_stage #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemRdata,
  input  logic              imemValid,
  input  logic              stall,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic [31:0]       instrOut,
  output logic [5:0]        opCode,
  output logic [ADDR_W-1:0] pcPlus4Out,
  output logic              ifidValid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       skid_reg, skid_next;
  logic              discard_reg, discard_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] pc_plus4_reg, pc_plus4_next;
  logic              valid_reg, valid_next;
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_reg + ADDR_W'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_FETCH;
      pc_reg       <= RESET_PC;
      skid_reg     <= '0;
      discard_reg  <= 1'b0;
      instr_reg    <= '0;
      pc_plus4_reg <= '0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      skid_reg     <= skid_next;
      discard_reg  <= discard_next;
      instr_reg    <= instr_next;
      pc_plus4_reg <= pc_plus4_next;
      valid_reg    <= valid_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    skid_next     = skid_reg;
    discard_next  = discard_reg;
    instr_next    = instr_reg;
    pc_plus4_next = pc_plus4_reg;
    valid_next    = valid_reg;
    if (branchTaken) begin
      // Redirect wins over everything, including stall, and flushes IF/ID.
      pc_next       = {branchTarget[ADDR_W-1:2], 2'b00};
      instr_next    = '0;
      pc_plus4_next = '0;
      valid_next    = 1'b0;
      case (state_reg)
        S_WAIT: begin
          if (imemValid) begin
            state_next   = S_FETCH;
            discard_next = 1'b0;
          end else begin
            discard_next = 1'b1;
          end
        end
        S_HOLD:  state_next = S_FETCH;
        default: state_next = S_FETCH;
      endcase
    end else begin
      case (state_reg)
        S_FETCH: state_next = S_WAIT;
        S_WAIT: begin
          if (imemValid) begin
            if (discard_reg) begin
              discard_next = 1'b0;
              state_next   = S_FETCH;
            end else if (!stall) begin
              instr_next    = imemRdata;
              pc_plus4_next = pc_inc;
              valid_next    = 1'b1;
              pc_next       = pc_inc;
              state_next    = S_FETCH;
            end else begin
              skid_next  = imemRdata;
              state_next = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            instr_next    = skid_reg;
            pc_plus4_next = pc_inc;
            valid_next    = 1'b1;
            pc_next       = pc_inc;
            state_next    = S_FETCH;
          end
        end
        default: state_next = S_FETCH;
      endcase
    end
  end

  always_comb begin
    imemReq    = rst_n && (state_reg == S_FETCH) && !branchTaken;
    imemAddr   = pc_reg;
    instrOut   = instr_reg;
    opCode     = instr_reg[31:26];
    pcPlus4Out = pc_plus4_reg;
    ifidValid  = valid_reg;
  end

endmodule
